redirect_ctrl: RTL and testbench
================================

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter BTB_Q_DEPTH, default 4, meaning BTB-update queue entries (power of two, at least 2).
REQ-002 SHALL have parameter AW, default `INST_ADDR_WIDTH, meaning the instruction address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-004 int_req_i  in  1  interrupt redirect request; int_addr_i  in  AW  interrupt/trap target.
REQ-005 bru0_jump_i  in  1  older-slot BRU jump flag; bru0_addr_i  in  AW  its target.
REQ-006 bru1_jump_i  in  1  younger-slot BRU jump flag; bru1_addr_i  in  AW  its target.
REQ-007 btb_upd_valid_i  in  1, btb_upd_pc_i  in  AW, btb_upd_target_i  in  AW: the BRU JALR BTB-update request.
REQ-008 ifu_redirect_valid_o  out  1, ifu_redirect_addr_o  out  AW, ifu_redirect_ready_i  in  1: the valid/ready redirect to the IFU.
REQ-009 flush_o  out  1  one-cycle pipeline flush pulse; hold_o  out  1  front-end stall while a redirect is pending.
REQ-010 btb_wr_valid_o  out  1, btb_wr_pc_o  out  AW, btb_wr_target_o  out  AW, btb_wr_ready_i  in  1: the BTB write port.
REQ-011 btb_q_full_o  out  1  queue full; btb_q_drop_o  out  1  one-cycle pulse when an update is discarded.

Function
REQ-012 SHALL implement FSM states IDLE and PEND; reset state IDLE.
REQ-013 Request priority SHALL be int > bru0 > bru1; bru1 is considered only when int_req_i=0 and bru0_jump_i=0.
REQ-014 A request sampled in IDLE at cycle N SHALL give ifu_redirect_valid_o=1, the winning address on ifu_redirect_addr_o, flush_o=1 and state PEND at cycle N+1 (registered, 1-cycle latency).
REQ-015 In PEND, ifu_redirect_valid_o and ifu_redirect_addr_o SHALL hold stable until ifu_redirect_ready_i=1.
REQ-016 PEND with ready=1 and no int_req_i SHALL return to IDLE next cycle.
REQ-017 In PEND, bru0/bru1 requests SHALL be ignored because they are wrong-path.
REQ-018 int_req_i in PEND SHALL replace the address with int_addr_i, pulse flush_o again and remain in PEND; this includes the cycle where ready=1, in which the old address is consumed and the new one is presented next cycle.
REQ-019 hold_o SHALL equal (state==PEND).
REQ-020 flush_o SHALL be 1 for exactly one cycle per accepted or replacing redirect.
REQ-021 The BTB queue SHALL be FIFO-ordered, depth BTB_Q_DEPTH, storing {pc,target}.
REQ-022 Push SHALL occur on btb_upd_valid_i when not full, or when full with a same-cycle pop.
REQ-023 Pop SHALL occur on btb_wr_valid_o & btb_wr_ready_i.
REQ-024 btb_wr_valid_o SHALL be 1 when the queue is not empty, with the head entry on pc/target; there is no bypass, so a push is visible the next cycle.
REQ-025 An update arriving when full with no pop SHALL be discarded and SHALL pulse btb_q_drop_o for one cycle; the contents are unchanged.
REQ-026 Pointers SHALL wrap modulo BTB_Q_DEPTH; a count register SHALL disambiguate full from empty.
REQ-027 flush_o SHALL NOT clear the BTB queue.

Reset
REQ-028 With rst=1 at a clock edge: state=IDLE; ifu_redirect_valid_o, flush_o, hold_o, btb_wr_valid_o, btb_q_full_o and btb_q_drop_o = 0; ifu_redirect_addr_o = 0; queue count and pointers = 0.
REQ-029 Reset mid-PEND or with a non-empty queue SHALL abandon the pending redirect and all queued entries without a handshake.

Structure
REQ-030 The state enum redirect_state_e {IDLE,PEND} and the BTB entry struct {pc,target} SHALL reside in the shared package alioth_pkg.
REQ-031 The BTB queue SHALL be the sub-module redirect_btb_fifo, and the FSM SHALL be in redirect_ctrl.

Verification
REQ-032 bru0_jump_i=1, bru0_addr_i=0x100 and bru1_jump_i=1, bru1_addr_i=0x200 at cycle N, with ready=1 -> valid=1, addr=0x100, flush pulse at N+1; IDLE at N+2.
REQ-033 bru1 request 0x300 with ready=0 for 3 cycles and a bru0 request during PEND -> addr stays 0x300 and hold_o=1 throughout; no second flush.
REQ-034 PEND at 0x300 and int_req_i=1, int_addr_i=0x80 on the ready=1 cycle -> 0x300 consumed; next cycle valid=1, addr=0x80, flush pulse.
REQ-035 Five updates pushed with btb_wr_ready_i=0 -> full after 4; the fifth gives btb_q_drop_o pulse; draining outputs the first four in order.
REQ-036 Queue full, simultaneous push and pop -> no drop; count stays 4; order is preserved across pointer wrap.
REQ-037 rst=1 asserted while in PEND with 2 entries queued -> all outputs 0 next cycle; a new request afterwards shows 1-cycle latency.

Source files
------------

// File: rtl/alioth_pkg.sv
// Shared types for the redirect controller: FSM state encoding and BTB update entry.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package alioth_pkg;

  localparam int INST_ADDR_W = `INST_ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } redirect_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_ADDR_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/redirect_btb_fifo.sv
// FIFO of pending BTB updates; head is exposed directly (no write-through bypass).
module redirect_btb_fifo
  import alioth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  btb_entry_t in_data,
  output logic       out_valid,
  output btb_entry_t out_data,
  input  logic       out_ready,
  output logic       full,
  output logic       drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  btb_entry_t       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty && out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect arbiter (int > bru0 > bru1) with valid/ready IFU handshake,
// plus a queue that serialises JALR BTB updates onto the BTB write port.
module redirect_ctrl
  import alioth_pkg::*;
#(
  parameter int BTB_Q_DEPTH = 4,
  parameter int AW          = `INST_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_req_i,
  input  logic [AW-1:0] int_addr_i,
  input  logic          bru0_jump_i,
  input  logic [AW-1:0] bru0_addr_i,
  input  logic          bru1_jump_i,
  input  logic [AW-1:0] bru1_addr_i,
  input  logic          btb_upd_valid_i,
  input  logic [AW-1:0] btb_upd_pc_i,
  input  logic [AW-1:0] btb_upd_target_i,
  output logic          ifu_redirect_valid_o,
  output logic [AW-1:0] ifu_redirect_addr_o,
  input  logic          ifu_redirect_ready_i,
  output logic          flush_o,
  output logic          hold_o,
  output logic          btb_wr_valid_o,
  output logic [AW-1:0] btb_wr_pc_o,
  output logic [AW-1:0] btb_wr_target_o,
  input  logic          btb_wr_ready_i,
  output logic          btb_q_full_o,
  output logic          btb_q_drop_o
);

  redirect_state_e state;
  redirect_state_e state_nxt;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_nxt;
  logic            flush_q;
  logic            flush_nxt;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    flush_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (int_req_i) begin
          state_nxt = PEND;
          addr_nxt  = int_addr_i;
          flush_nxt = 1'b1;
        end else if (bru0_jump_i) begin
          state_nxt = PEND;
          addr_nxt  = bru0_addr_i;
          flush_nxt = 1'b1;
        end else if (bru1_jump_i) begin
          state_nxt = PEND;
          addr_nxt  = bru1_addr_i;
          flush_nxt = 1'b1;
        end
      end
      PEND: begin
        // Branch requests here are wrong-path; only a trap may retarget.
        // On a ready cycle the old address is consumed and the trap follows.
        if (int_req_i) begin
          addr_nxt  = int_addr_i;
          flush_nxt = 1'b1;
        end else if (ifu_redirect_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      flush_q <= flush_nxt;
    end
  end

  assign ifu_redirect_valid_o = (state == PEND);
  assign ifu_redirect_addr_o  = addr_q;
  assign flush_o              = flush_q;
  assign hold_o               = (state == PEND);

  btb_entry_t upd_entry;
  btb_entry_t head_entry;

  assign upd_entry.pc     = btb_upd_pc_i;
  assign upd_entry.target = btb_upd_target_i;

  redirect_btb_fifo #(
    .DEPTH (BTB_Q_DEPTH)
  ) u_btb_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (btb_upd_valid_i),
    .in_data   (upd_entry),
    .out_valid (btb_wr_valid_o),
    .out_data  (head_entry),
    .out_ready (btb_wr_ready_i),
    .full      (btb_q_full_o),
    .drop      (btb_q_drop_o)
  );

  assign btb_wr_pc_o     = head_entry.pc;
  assign btb_wr_target_o = head_entry.target;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_redirect_ctrl;

  localparam int D  = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          int_req = 1'b0;
  logic [AW-1:0] int_addr = '0;
  logic          bru0 = 1'b0;
  logic [AW-1:0] bru0_addr = '0;
  logic          bru1 = 1'b0;
  logic [AW-1:0] bru1_addr = '0;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic [AW-1:0] upd_tg = '0;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready = 1'b0;
  logic          flush;
  logic          hold;
  logic          wr_valid;
  logic [AW-1:0] wr_pc;
  logic [AW-1:0] wr_tg;
  logic          wr_ready = 1'b0;
  logic          q_full;
  logic          q_drop;

  redirect_ctrl #(.BTB_Q_DEPTH(D), .AW(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .int_req_i            (int_req),
    .int_addr_i           (int_addr),
    .bru0_jump_i          (bru0),
    .bru0_addr_i          (bru0_addr),
    .bru1_jump_i          (bru1),
    .bru1_addr_i          (bru1_addr),
    .btb_upd_valid_i      (upd_valid),
    .btb_upd_pc_i         (upd_pc),
    .btb_upd_target_i     (upd_tg),
    .ifu_redirect_valid_o (rd_valid),
    .ifu_redirect_addr_o  (rd_addr),
    .ifu_redirect_ready_i (rd_ready),
    .flush_o              (flush),
    .hold_o               (hold),
    .btb_wr_valid_o       (wr_valid),
    .btb_wr_pc_o          (wr_pc),
    .btb_wr_target_o      (wr_tg),
    .btb_wr_ready_i       (wr_ready),
    .btb_q_full_o         (q_full),
    .btb_q_drop_o         (q_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] tg;
  } ent_t;

  int            vectors = 0;
  int            miscompares = 0;
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_addr = '0;
  bit            m_flush = 1'b0;
  ent_t          mq[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect behaviour: one outstanding target, traps may retarget it, branches may not.
  task automatic model_update();
    bit   pop;
    bit   push;
    ent_t e;
    if (rst) begin
      m_pend  = 1'b0;
      m_addr  = '0;
      m_flush = 1'b0;
      mq.delete();
    end else begin
      pop  = (mq.size() > 0) && wr_ready;
      push = upd_valid && ((mq.size() < D) || pop);
      m_flush = 1'b0;
      if (!m_pend) begin
        if (int_req || bru0 || bru1) begin
          m_pend  = 1'b1;
          m_flush = 1'b1;
          m_addr  = int_req ? int_addr : (bru0 ? bru0_addr : bru1_addr);
        end
      end else if (int_req) begin
        m_addr  = int_addr;
        m_flush = 1'b1;
      end else if (rd_ready) begin
        m_pend = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = upd_pc;
        e.tg = upd_tg;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cmp_model();
    bit exp_drop;
    exp_drop = upd_valid && (mq.size() == D) && !wr_ready;
    chk("valid", {31'd0, rd_valid}, {31'd0, m_pend});
    chk("hold", {31'd0, hold}, {31'd0, m_pend});
    chk("addr", rd_addr, m_addr);
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("wr_valid", {31'd0, wr_valid}, {31'd0, mq.size() > 0});
    chk("full", {31'd0, q_full}, {31'd0, mq.size() == D});
    chk("drop", {31'd0, q_drop}, {31'd0, exp_drop});
    if (mq.size() > 0) begin
      chk("wr_pc", wr_pc, mq[0].pc);
      chk("wr_tg", wr_tg, mq[0].tg);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push_upd(input logic [AW-1:0] pc, input logic [AW-1:0] tg);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_tg    = tg;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_addr", rd_addr, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    step();

    // bru0 beats bru1; ready already high so it is consumed after one cycle
    rd_ready = 1'b1;
    bru0 = 1'b1; bru0_addr = 32'h100;
    bru1 = 1'b1; bru1_addr = 32'h200;
    step();
    bru0 = 1'b0; bru1 = 1'b0;
    chk("pri_valid", {31'd0, rd_valid}, 32'd1);
    chk("pri_addr", rd_addr, 32'h100);
    chk("pri_flush", {31'd0, flush}, 32'd1);
    step();
    chk("pri_idle", {31'd0, hold}, 32'd0);
    chk("pri_flush_off", {31'd0, flush}, 32'd0);

    // Stall with a wrong-path bru0 arriving during PEND
    rd_ready = 1'b0;
    bru1 = 1'b1; bru1_addr = 32'h300;
    step();
    bru1 = 1'b0;
    chk("stall_addr0", rd_addr, 32'h300);
    bru0 = 1'b1; bru0_addr = 32'h400;
    step();
    bru0 = 1'b0;
    chk("stall_addr1", rd_addr, 32'h300);
    chk("stall_flush", {31'd0, flush}, 32'd0);
    step();
    chk("stall_hold", {31'd0, hold}, 32'd1);

    // Trap on the ready cycle replaces the consumed target
    rd_ready = 1'b1;
    int_req = 1'b1; int_addr = 32'h80;
    step();
    int_req = 1'b0;
    rd_ready = 1'b0;
    chk("int_addr", rd_addr, 32'h80);
    chk("int_flush", {31'd0, flush}, 32'd1);
    chk("int_valid", {31'd0, rd_valid}, 32'd1);
    rd_ready = 1'b1;
    step();
    chk("int_done", {31'd0, rd_valid}, 32'd0);

    // Five updates with the BTB stalled: fifth is dropped
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_upd(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16));
      #1;
      if (i == 4) chk("drop5", {31'd0, q_drop}, 32'd1);
      step();
    end
    upd_valid = 1'b0;
    #1;
    chk("full4", {31'd0, q_full}, 32'd1);
    chk("nodrop_idle", {31'd0, q_drop}, 32'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", wr_pc, 32'h1000 + 32'(i * 4));
      chk("drain_tg", wr_tg, 32'h2000 + 32'(i * 16));
      step();
    end
    chk("drained", {31'd0, wr_valid}, 32'd0);

    // Full queue with simultaneous push/pop across pointer wrap
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_upd(32'h3000 + 32'(i * 4), 32'h5000 + 32'(i * 4));
      step();
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_upd(32'h4000 + 32'(i * 4), 32'h6000 + 32'(i * 4));
      #1;
      chk("pp_drop", {31'd0, q_drop}, 32'd0);
      chk("pp_head", wr_pc, 32'h3000 + 32'(i * 4));
      step();
      chk("pp_full", {31'd0, q_full}, 32'd1);
    end
    upd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_head", wr_pc, 32'h4000 + 32'(i * 4));
      step();
    end

    // Reset abandons a pending redirect and queued entries
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_upd(32'h7000 + 32'(i * 4), 32'h8000);
      step();
    end
    upd_valid = 1'b0;
    bru0 = 1'b1; bru0_addr = 32'h500;
    step();
    bru0 = 1'b0;
    chk("pre_rst_hold", {31'd0, hold}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("post_rst_hold", {31'd0, hold}, 32'd0);
    chk("post_rst_addr", rd_addr, 32'd0);
    chk("post_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    int_req = 1'b1; int_addr = 32'h600;
    step();
    int_req = 1'b0;
    chk("post_rst_req_addr", rd_addr, 32'h600);
    chk("post_rst_req_flush", {31'd0, flush}, 32'd1);
    rd_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
